// File: rtl/imem_loadable.sv
// Instruction memory for the fetch stage. Programs are written through a valid/ready
// boot-load port, and a clear engine fills the whole array with NOP words.
module imem_loadable #(
  parameter int                 DATA_W       = 16,
  parameter int                 ADDR_W       = 10,
  parameter int                 DEPTH        = 1024,
  parameter int                 PC_W         = 16,
  parameter logic [DATA_W-1:0]  NOP_WORD     = '0,
  parameter bit                 REG_OUT      = 1'b1,
  parameter bit                 CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] op,
  output logic              op_valid,
  output logic              busy,
  input  logic              clr_req,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [PC_W:0]     DEPTH_PC  = (PC_W + 1)'(DEPTH);
  localparam state_t            RST_STATE = CLEAR_ON_RST ? S_CLEAR : S_IDLE;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic                ld_err_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                beat;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                pc_in_range;
  logic [DATA_W-1:0]   op_d;
  logic                op_valid_d;

  assign busy     = (state_q != S_IDLE);
  assign ld_ready = (state_q == S_LOAD);
  assign ld_err   = ld_err_q;
  assign beat     = ld_valid & ld_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_ptr_q <= '0;
      wr_ptr_q  <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // clr_req has priority; a simultaneous ld_start is simply dropped
          if (clr_req) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
          end else if (ld_start) begin
            state_q  <= S_LOAD;
            wr_ptr_q <= ld_base;
            ld_err_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (clr_ptr_q == LAST_ADDR) begin
            state_q   <= S_IDLE;
            clr_ptr_q <= '0;
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            if (wr_ptr_q == LAST_ADDR) begin
              wr_ptr_q <= '0;
              ld_err_q <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (ld_last) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Writes only happen while busy, so fetch reads never race a write.
  always_comb begin
    mem_we    = (state_q == S_CLEAR) | beat;
    mem_waddr = (state_q == S_CLEAR) ? clr_ptr_q : wr_ptr_q;
    mem_wdata = (state_q == S_CLEAR) ? NOP_WORD : ld_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Full-width compare so large pc values fetch NOP instead of aliasing.
  assign pc_in_range = ({1'b0, pc} < DEPTH_PC);
  assign op_d        = (busy | ~pc_in_range) ? NOP_WORD : mem_q[pc[ADDR_W-1:0]];
  assign op_valid_d  = fetch_en & ~busy;

  generate
    if (REG_OUT) begin : g_reg_out
      logic [DATA_W-1:0] op_q;
      logic              op_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          op_q       <= NOP_WORD;
          op_valid_q <= 1'b0;
        end else begin
          op_valid_q <= op_valid_d;
          if (op_valid_d) op_q <= op_d;
        end
      end

      assign op       = op_q;
      assign op_valid = op_valid_q;
    end else begin : g_comb_out
      assign op       = op_d;
      assign op_valid = op_valid_d;
    end
  endgenerate

endmodule

// File: tb/tb_imem_loadable.sv
// Randomized bench for imem_loadable (DEPTH=64, registered fetch) against a flat
// array model of the memory contents and the expected status flags.
module tb_imem_loadable;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int PC_W   = 16;
  localparam logic [DATA_W-1:0] NOP = 16'h0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PC_W-1:0]   pc;
  logic              fetch_en;
  logic [DATA_W-1:0] op;
  logic              op_valid;
  logic              busy;
  logic              clr_req;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_err;

  imem_loadable #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PC_W(PC_W),
    .NOP_WORD(NOP), .REG_OUT(1'b1), .CLEAR_ON_RST(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en), .op(op),
    .op_valid(op_valid), .busy(busy), .clr_req(clr_req), .ld_start(ld_start),
    .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] burst_w [16];
  logic [DATA_W-1:0] exp_op;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
  endtask

  task automatic fetch_chk(input logic [PC_W-1:0] a);
    logic [DATA_W-1:0] e;
    @(negedge clk);
    pc = a;
    fetch_en = 1'b1;
    @(negedge clk);
    e = (int'(a) < DEPTH) ? model[int'(a)] : NOP;
    check($sformatf("op[pc=%h]", a), 32'(op), 32'(e));
    check($sformatf("op_valid[pc=%h]", a), 32'(op_valid), 32'd1);
    exp_op = e;
    fetch_en = 1'b0;
  endtask

  task automatic check_all();
    for (int a = 0; a < DEPTH; a++) fetch_chk(PC_W'(a));
  endtask

  // Samples busy on successive falling edges; returns how many rising edges saw busy high.
  task automatic count_busy(input int vskip, output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      check("ld_ready_in_clear", 32'(ld_ready), 32'd0);
      check("op_hold_in_clear", 32'(op), 32'(exp_op));
      if (k >= vskip) check("op_valid_in_clear", 32'(op_valid), 32'd0);
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic load_burst(input logic [ADDR_W-1:0] base, input int n, input bit gaps);
    bit err_exp;
    @(negedge clk);
    ld_start = 1'b1;
    ld_base  = base;
    @(negedge clk);
    ld_start = 1'b0;
    check("ld_ready_open", 32'(ld_ready), 32'd1);
    check("ld_err_cleared", 32'(ld_err), 32'd0);
    fetch_en = 1'b1;
    pc = PC_W'($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid = 1'b0;
          @(negedge clk);
          check("op_valid_in_load", 32'(op_valid), 32'd0);
        end
      end
      ld_valid = 1'b1;
      ld_data  = burst_w[i];
      ld_last  = (i == n - 1);
      @(negedge clk);
      model[(int'(base) + i) % DEPTH] = burst_w[i];
      check("op_valid_in_load", 32'(op_valid), 32'd0);
      check("op_hold_in_load", 32'(op), 32'(exp_op));
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    fetch_en = 1'b0;
    err_exp  = (int'(base) + n - 1) >= (DEPTH - 1);
    check("ld_ready_closed", 32'(ld_ready), 32'd0);
    check("busy_after_load", 32'(busy), 32'd0);
    check("ld_err_after_load", 32'(ld_err), 32'(err_exp));
  endtask

  initial begin
    int cnt;
    int base;
    int n;
    rst_n = 1'b0; pc = '0; fetch_en = 1'b0; clr_req = 1'b0; ld_start = 1'b0;
    ld_base = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    exp_op = NOP;

    // Reset values, then the automatic clear
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_op", 32'(op), 32'(NOP));
    check("rst_ld_err", 32'(ld_err), 32'd0);
    rst_n = 1'b1;
    count_busy(0, cnt);
    check("clear_len_after_rst", 32'(cnt), 32'd64);
    model_clear();
    check_all();

    // Basic burst
    burst_w[0] = 16'hA003; burst_w[1] = 16'hB1FF; burst_w[2] = 16'hC000;
    load_burst(6'd5, 3, 1'b0);
    fetch_chk(16'd5); fetch_chk(16'd6); fetch_chk(16'd7); fetch_chk(16'd8);

    // Wrapping burst sets a sticky error
    burst_w[0] = 16'h1111; burst_w[1] = 16'h2222; burst_w[2] = 16'h3333; burst_w[3] = 16'h4444;
    load_burst(6'd62, 4, 1'b1);
    fetch_chk(16'd62); fetch_chk(16'd63); fetch_chk(16'd0); fetch_chk(16'd1); fetch_chk(16'd2);
    check("ld_err_sticky", 32'(ld_err), 32'd1);

    // Out-of-range fetches
    fetch_chk(16'h0040);
    fetch_chk(16'hFFFF);
    fetch_chk(16'h0045);

    // clr_req and ld_start together, fetch_en held, ld_valid ignored during clear
    @(negedge clk);
    pc = 16'd5; fetch_en = 1'b1;
    @(negedge clk);
    check("op_before_clr", 32'(op), 32'(model[5]));
    clr_req = 1'b1; ld_start = 1'b1; ld_base = 6'd3;
    ld_valid = 1'b1; ld_data = 16'hBEEF;
    @(negedge clk);
    clr_req = 1'b0; ld_start = 1'b0;
    check("op_valid_entry_clr", 32'(op_valid), 32'd1);
    exp_op = model[5];
    count_busy(1, cnt);
    check("clear_len_on_req", 32'(cnt), 32'd64);
    check("op_valid_end_clr", 32'(op_valid), 32'd0);
    check("ld_err_kept_by_clr", 32'(ld_err), 32'd1);
    fetch_en = 1'b0;
    @(negedge clk);
    check("ld_ready_idle_pulse", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0;
    model_clear();
    check_all();

    // Reset in the middle of a burst
    @(negedge clk);
    ld_start = 1'b1; ld_base = 6'd20;
    @(negedge clk);
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 16'h5A5A;
    @(negedge clk);
    ld_data = 16'hA5A5;
    @(negedge clk);
    ld_data = 16'h7777;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd1);
    check("rst_mid_op", 32'(op), 32'(NOP));
    ld_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_op = NOP;
    count_busy(0, cnt);
    check("clear_len_after_mid_rst", 32'(cnt), 32'd64);
    model_clear();
    fetch_chk(16'd20); fetch_chk(16'd21); fetch_chk(16'd22);

    // Random bursts and fetches
    for (int t = 0; t < 8; t++) begin
      base = $urandom_range(0, DEPTH - 1);
      n    = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) burst_w[i] = DATA_W'($urandom);
      load_burst(ADDR_W'(base), n, 1'b1);
      for (int i = 0; i < n; i++) fetch_chk(PC_W'((base + i) % DEPTH));
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) fetch_chk(PC_W'($urandom));
        else fetch_chk(PC_W'($urandom_range(0, DEPTH + 8)));
      end
    end
    check_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
